// File: rtl/sum_accum_serializer_if.sv
// sum_accum_serializer_if: sample input and byte output handshakes.
// The master drives samples and out_ready; the slave is the serializer.
interface sum_accum_serializer_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/sum_accum_serializer.sv
// sum_accum_serializer: accumulates 8-bit sums, streams the total MSB-first.
// Define SUM_ACCUM_SAT_EN to clamp the accumulator instead of wrapping.
module sum_accum_serializer #(
    parameter int ACC_W = 16,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sum_accum_serializer_if.slave bus,
    input  logic                 flush,
    output logic [CNT_W-1:0]     count,
    output logic                 ovf
);
    localparam int NB   = ACC_W / 8;
    localparam int BC_W = $clog2(NB + 1);
    localparam int SW   = ACC_W + 1;

    typedef enum logic {ACCUM, SEND} state_t;

    state_t           state;
    state_t           state_next;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic [ACC_W-1:0] shift;
    logic [BC_W-1:0]  bytes;
    logic [ACC_W:0]   sum;
    logic             accept;
    logic             carry;
    logic             snap;
    logic             last;

    assign accept = (state == ACCUM) && bus.in_valid;
    assign sum    = {1'b0, acc} + SW'(bus.in_data);
    assign carry  = accept && sum[ACC_W];
    assign snap   = (state == ACCUM) && flush;
    assign last   = (state == SEND) && bus.out_ready
                    && (bytes == BC_W'(1));

    // Outputs decode from state and registers only.
    assign bus.in_ready  = (state == ACCUM);
    assign bus.out_valid = (state == SEND);
    assign bus.out_data  = (state == SEND) ? shift[ACC_W-1 -: 8] : 8'h00;

    // Post-update accumulator value, also the snapshot source on flush.
    always_comb begin
        acc_next = acc;
        if (accept) begin
`ifdef SUM_ACCUM_SAT_EN
            acc_next = carry ? '1 : sum[ACC_W-1:0];
`else
            acc_next = sum[ACC_W-1:0];
`endif
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ACCUM;
        else        state <= state_next;
    end

    // Next state: flush leaves ACCUM, the last accepted byte returns.
    always_comb begin
        state_next = state;
        unique case (state)
            ACCUM:   if (flush) state_next = SEND;
            SEND:    if (last)  state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    // Accumulate, snapshot into the shifter, and shift out on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            shift <= '0;
            bytes <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (snap) begin
            shift <= acc_next;
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
            bytes <= BC_W'(NB);
        end else if (state == ACCUM) begin
            acc <= acc_next;
            if (accept && count != '1) count <= count + CNT_W'(1);
            if (carry) ovf <= 1'b1;
        end else if (bus.out_ready) begin
            shift <= shift << 8;
            bytes <= bytes - BC_W'(1);
        end
    end
endmodule

// File: tb/tb_sum_accum_serializer.sv
// tb_sum_accum_serializer: scoreboard bench with a behavioural total model.
// Expected bytes are queued on flush and popped by an output monitor.
module tb_sum_accum_serializer;
    localparam int ACC_W = 16;
    localparam int CNT_W = 8;
    localparam int NB    = ACC_W / 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic [CNT_W-1:0] count;
    logic             ovf;

    sum_accum_serializer_if bus ();

    sum_accum_serializer #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .flush (flush),
        .count (count),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [7:0] expq[$];

    // Behavioural model: sum since last snapshot and protocol phase.
    longint m_total;
    int     m_cnt;
    bit     m_accum;
    int     m_left;

    function automatic bit m_ovf();
        return m_total >= (64'd1 << ACC_W);
    endfunction

    function automatic longint m_value();
`ifdef SUM_ACCUM_SAT_EN
        if (m_total >= (64'd1 << ACC_W)) return (64'd1 << ACC_W) - 1;
        return m_total;
`else
        return m_total % (64'd1 << ACC_W);
`endif
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_total = 0;
        m_cnt   = 0;
        m_accum = 1'b1;
        m_left  = 0;
        expq.delete();
    endtask

    // Apply inputs for one cycle, check visible state, advance model.
    task automatic step(input bit v, input logic [7:0] d,
                        input bit f, input bit r);
        longint val;
        bus.in_valid  = v;
        bus.in_data   = d;
        flush         = f;
        bus.out_ready = r;
        chk("in_ready", bus.in_ready, m_accum);
        chk("count", count, m_cnt);
        chk("ovf", ovf, m_ovf());
        if (m_accum) begin
            if (v) begin
                m_total += d;
                if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
            end
            if (f) begin
                val = m_value();
                for (int i = NB - 1; i >= 0; i--)
                    expq.push_back(8'((val >> (8 * i)) & 8'hFF));
                m_total = 0;
                m_cnt   = 0;
                m_accum = 1'b0;
                m_left  = NB;
            end
        end else if (r) begin
            m_left--;
            if (m_left == 0) m_accum = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < NB + 2; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("queue_empty", expq.size(), 0);
    endtask

    // Output monitor: compares each presented byte with the queue head.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.out_valid) begin
                if (expq.size() == 0) begin
                    chk("unexpected_byte", bus.out_data, -1);
                end else if (bus.out_ready) begin
                    chk("out_byte", bus.out_data, expq.pop_front());
                end else begin
                    chk("held_byte", bus.out_data, expq[0]);
                end
            end else begin
                chk("idle_data", bus.out_data, 0);
            end
        end
    end

    initial begin
        model_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;
        flush         = 1'b0;

        // Reset with random inputs toggling.
        for (int i = 0; i < 4; i++) begin
            bus.in_valid  = 1'($urandom);
            bus.in_data   = 8'($urandom);
            flush         = 1'($urandom);
            bus.out_ready = 1'($urandom);
            @(posedge clk);
            #1;
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_out_data", bus.out_data, 0);
            chk("rst_count", count, 0);
            chk("rst_ovf", ovf, 0);
            chk("rst_in_ready", bus.in_ready, 1);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0, 1'b1);

        // Basic: 3 + 5 + 250 = 0x0102.
        step(1'b1, 8'd3, 1'b0, 1'b1);
        step(1'b1, 8'd5, 1'b0, 1'b1);
        step(1'b1, 8'd250, 1'b0, 1'b1);
        chk("basic_count", count, 3);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        drain();

        // Backpressure: four stalled cycles after flush.
        step(1'b1, 8'd3, 1'b0, 1'b1);
        step(1'b1, 8'd5, 1'b0, 1'b1);
        step(1'b1, 8'd250, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("bp_valid", bus.out_valid, 1);
            chk("bp_data", bus.out_data, 8'h01);
            step(1'b1, 8'h55, 1'b1, 1'b0);
        end
        drain();

        // Overflow: 258 x 0xFF.
        for (int i = 0; i < 258; i++) step(1'b1, 8'hFF, 1'b0, 1'b1);
        chk("ovf_count", count, 255);
        chk("ovf_flag", ovf, 1);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        drain();

        // Flush together with a sample, then a fresh total.
        step(1'b1, 8'd10, 1'b0, 1'b1);
        step(1'b1, 8'd20, 1'b1, 1'b1);
        drain();
        step(1'b1, 8'd7, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        drain();

        // Reset in the middle of an emission.
        step(1'b1, 8'h80, 1'b0, 1'b1);
        step(1'b1, 8'h82, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        bus.out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_out_data", bus.out_data, 0);
        chk("midrst_in_ready", bus.in_ready, 1);
        chk("midrst_count", count, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b0, 8'h00, 1'b1, 1'b1);
        drain();

        // Random traffic with random backpressure.
        for (int i = 0; i < 400; i++)
            step(1'($urandom), 8'($urandom),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 3) != 0));
        for (int i = 0; i < 20 && expq.size() != 0; i++)
            step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("final_queue_empty", expq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
